// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU data port
// and a block-granular memory using a valid/ready request protocol.
module cache_controller #(
  parameter int NUM_SETS   = 16,
  parameter int BLOCK_SIZE = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         is_input_valid,
  input  logic [31:0]  addr,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  din,
  output logic         is_ready,
  output logic         is_output_valid,
  output logic [31:0]  dout,
  output logic         is_hit,
  output logic         mem_is_input_valid,
  output logic [31:0]  mem_addr,
  output logic         mem_rd,
  output logic         mem_wr,
  output logic [127:0] mem_din,
  input  logic [127:0] mem_dout,
  input  logic         mem_is_output_valid,
  input  logic         mem_ready,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int IDX  = $clog2(NUM_SETS);
  localparam int OFFW = $clog2(BLOCK_SIZE);
  localparam int TAGW = 32 - IDX - OFFW;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WB_REQ    = 3'd1,
    WB_WAIT   = 3'd2,
    FILL_REQ  = 3'd3,
    FILL_WAIT = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_SETS-1:0] valid_q, dirty_q;
  logic [TAGW-1:0]     tag_q  [NUM_SETS];
  logic [127:0]        data_q [NUM_SETS];
  logic [31:0]         hit_count_q, miss_count_q;
  logic                refill_done_q;

  logic [IDX-1:0]      idx_s;
  logic [TAGW-1:0]     tag_s;
  logic [1:0]          word_s;
  logic [127:0]        line_s;
  logic                hit_s;
  logic                miss_s;
  logic                fill_s;
  logic                unused_addr_s;

  assign idx_s         = addr[IDX+OFFW-1:OFFW];
  assign tag_s         = addr[31:IDX+OFFW];
  assign word_s        = addr[3:2];
  assign line_s        = data_q[idx_s];
  assign unused_addr_s = &{1'b0, addr[1:0]};

  assign hit_s  = (state_q == IDLE) && is_input_valid && valid_q[idx_s] && (tag_q[idx_s] == tag_s);
  assign fill_s = (state_q == FILL_WAIT) && mem_is_output_valid;

  assign is_ready        = (state_q == IDLE);
  assign is_hit          = hit_s;
  assign is_output_valid = hit_s && mem_read;
  assign dout            = (hit_s && mem_read) ? line_s[{word_s, 5'b00000} +: 32] : 32'd0;
  assign hit_count       = hit_count_q;
  assign miss_count      = miss_count_q;

  always_comb begin
    state_d            = state_q;
    miss_s             = 1'b0;
    mem_is_input_valid = 1'b0;
    mem_rd             = 1'b0;
    mem_wr             = 1'b0;
    mem_addr           = 32'd0;
    mem_din            = 128'd0;
    case (state_q)
      IDLE: begin
        if (is_input_valid && !hit_s) begin
          miss_s = 1'b1;
          if (valid_q[idx_s] && dirty_q[idx_s]) begin
            state_d = WB_REQ;
          end else begin
            state_d = FILL_REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WB_REQ: begin
        // Victim block address is rebuilt from its stored tag and the shared index.
        mem_is_input_valid = 1'b1;
        mem_wr             = 1'b1;
        mem_addr           = {{OFFW{1'b0}}, tag_q[idx_s], idx_s};
        mem_din            = line_s;
        if (mem_ready) begin
          state_d = WB_WAIT;
        end else begin
          state_d = WB_REQ;
        end
      end
      WB_WAIT: begin
        if (mem_ready) begin
          state_d = FILL_REQ;
        end else begin
          state_d = WB_WAIT;
        end
      end
      FILL_REQ: begin
        mem_is_input_valid = 1'b1;
        mem_rd             = 1'b1;
        mem_addr           = {{OFFW{1'b0}}, addr[31:OFFW]};
        if (mem_ready) begin
          state_d = FILL_WAIT;
        end else begin
          state_d = FILL_REQ;
        end
      end
      FILL_WAIT: begin
        if (mem_is_output_valid) begin
          state_d = IDLE;
        end else begin
          state_d = FILL_WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The hit that completes a refilled miss is not counted as a separate hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      hit_count_q   <= 32'd0;
      miss_count_q  <= 32'd0;
      refill_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      refill_done_q <= fill_s;
      if (hit_s && !refill_done_q) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if (miss_s) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_s) begin
      valid_q[idx_s] <= 1'b1;
      dirty_q[idx_s] <= 1'b0;
    end else if (hit_s && mem_write) begin
      dirty_q[idx_s] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_s) begin
      data_q[idx_s] <= mem_dout;
      tag_q[idx_s]  <= tag_s;
    end else if (hit_s && mem_write) begin
      data_q[idx_s][{word_s, 5'b00000} +: 32] <= din;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: a table of CPU accesses with hand-computed
// results against a small latency-modelled block memory, plus reset/idle sequences.
module tb_cache_controller;

  logic         clk;
  logic         reset;
  logic         is_input_valid;
  logic [31:0]  addr;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  din;
  logic         is_ready;
  logic         is_output_valid;
  logic [31:0]  dout;
  logic         is_hit;
  logic         mem_is_input_valid;
  logic [31:0]  mem_addr;
  logic         mem_rd;
  logic         mem_wr;
  logic [127:0] mem_din;
  logic [127:0] mem_dout;
  logic         mem_is_output_valid;
  logic         mem_ready;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  cache_controller #(.NUM_SETS(16), .BLOCK_SIZE(16)) dut (
    .clk                 (clk),
    .reset               (reset),
    .is_input_valid      (is_input_valid),
    .addr                (addr),
    .mem_read            (mem_read),
    .mem_write           (mem_write),
    .din                 (din),
    .is_ready            (is_ready),
    .is_output_valid     (is_output_valid),
    .dout                (dout),
    .is_hit              (is_hit),
    .mem_is_input_valid  (mem_is_input_valid),
    .mem_addr            (mem_addr),
    .mem_rd              (mem_rd),
    .mem_wr              (mem_wr),
    .mem_din             (mem_din),
    .mem_dout            (mem_dout),
    .mem_is_output_valid (mem_is_output_valid),
    .mem_ready           (mem_ready),
    .hit_count           (hit_count),
    .miss_count          (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block memory model: accepts one request when ready, busy for 3 cycles.
  logic [127:0] mem_q [256];
  logic [1:0]   lat;
  logic         pend_rd;
  logic [31:0]  pend_addr;
  logic [127:0] pend_data;
  logic [31:0]  rd_cnt, wr_cnt, last_rd_addr, first_wr_addr, last_wr_addr;
  logic [127:0] first_wr_data, last_wr_data;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ready           <= 1'b1;
      mem_is_output_valid <= 1'b0;
      mem_dout            <= 128'd0;
      lat                 <= 2'd0;
      pend_rd             <= 1'b0;
      pend_addr           <= 32'd0;
      pend_data           <= 128'd0;
      rd_cnt              <= 32'd0;
      wr_cnt              <= 32'd0;
      last_rd_addr        <= 32'd0;
      first_wr_addr       <= 32'd0;
      last_wr_addr        <= 32'd0;
      first_wr_data       <= 128'd0;
      last_wr_data        <= 128'd0;
      for (int i = 0; i < 256; i++) mem_q[i] <= 128'd0;
    end else begin
      mem_is_output_valid <= 1'b0;
      if (lat != 2'd0) begin
        lat <= lat - 2'd1;
        if (lat == 2'd1) begin
          mem_ready <= 1'b1;
          if (pend_rd) begin
            mem_dout            <= mem_q[pend_addr[7:0]];
            mem_is_output_valid <= 1'b1;
          end else begin
            mem_q[pend_addr[7:0]] <= pend_data;
          end
        end
      end else if (mem_is_input_valid && mem_ready) begin
        mem_ready <= 1'b0;
        lat       <= 2'd3;
        pend_rd   <= mem_rd;
        pend_addr <= mem_addr;
        pend_data <= mem_din;
        if (mem_rd) begin
          rd_cnt       <= rd_cnt + 32'd1;
          last_rd_addr <= mem_addr;
        end
        if (mem_wr) begin
          wr_cnt       <= wr_cnt + 32'd1;
          last_wr_addr <= mem_addr;
          last_wr_data <= mem_din;
          if (wr_cnt == 32'd0) begin
            first_wr_addr <= mem_addr;
            first_wr_data <= mem_din;
          end
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One CPU access held until it hits; reports whether the first cycle missed.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output logic missed, output logic [31:0] data, output logic ovalid,
                        output logic rdy_seen, output logic ok);
    @(negedge clk);
    is_input_valid = 1'b1;
    mem_read       = rd;
    mem_write      = wr;
    addr           = a;
    din            = d;
    #1;
    missed   = !is_hit;
    ok       = 1'b0;
    rdy_seen = 1'b0;
    data     = 32'd0;
    ovalid   = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (is_hit) begin
        ok     = 1'b1;
        data   = dout;
        ovalid = is_output_valid;
        break;
      end
      if (c > 0 && is_ready) rdy_seen = 1'b1;
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    is_input_valid = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] din;
    logic        miss;
    logic [31:0] dout;
    logic [31:0] hc;
    logic [31:0] mc;
    logic [31:0] rds;
    logic [31:0] wrs;
    logic [31:0] rd_addr;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic        missed, ovalid, rdy_seen, ok, found;
    logic [31:0] data;
    int          bad_rdy, bad_req;

    //            rd    wr    addr          din           miss  dout          hc     mc     rds    wrs    rd_addr
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 32'h0,        32'd0, 32'd1, 32'd1, 32'd0, 32'h00};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0004, 32'hDEADBEEF, 1'b0, 32'h0,        32'd1, 32'd1, 32'd1, 32'd0, 32'h00};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,        1'b0, 32'hDEADBEEF, 32'd2, 32'd1, 32'd1, 32'd0, 32'h00};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0004, 32'hDEADBEEF, 1'b0, 32'h0,        32'd3, 32'd1, 32'd1, 32'd0, 32'h00};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,        1'b1, 32'h0,        32'd3, 32'd2, 32'd2, 32'd1, 32'h10};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,        1'b1, 32'hDEADBEEF, 32'd3, 32'd3, 32'd3, 32'd1, 32'h00};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0208, 32'h12345678, 1'b1, 32'h0,        32'd3, 32'd4, 32'd4, 32'd1, 32'h20};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0208, 32'h0,        1'b0, 32'h12345678, 32'd4, 32'd4, 32'd4, 32'd1, 32'h20};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,        1'b1, 32'h0,        32'd4, 32'd5, 32'd5, 32'd1, 32'h01};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,        1'b1, 32'h0,        32'd4, 32'd6, 32'd6, 32'd2, 32'h00};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0208, 32'h0,        1'b1, 32'h12345678, 32'd4, 32'd7, 32'd7, 32'd2, 32'h20};

    reset          = 1'b1;
    is_input_valid = 1'b0;
    addr           = 32'd0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    din            = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_is_ready", 32'(is_ready), 32'd1);
    chk("rst_is_hit", 32'(is_hit), 32'd0);
    chk("rst_out_valid", 32'(is_output_valid), 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_mem_valid", 32'(mem_is_input_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din, missed, data, ovalid, rdy_seen, ok);
      chk($sformatf("v%0d_done", i), 32'(ok), 32'd1);
      chk($sformatf("v%0d_miss", i), 32'(missed), 32'(vecs[i].miss));
      chk($sformatf("v%0d_dout", i), data, vecs[i].dout);
      chk($sformatf("v%0d_out_valid", i), 32'(ovalid), 32'(vecs[i].rd));
      chk($sformatf("v%0d_hit_count", i), hit_count, vecs[i].hc);
      chk($sformatf("v%0d_miss_count", i), miss_count, vecs[i].mc);
      chk($sformatf("v%0d_mem_reads", i), rd_cnt, vecs[i].rds);
      chk($sformatf("v%0d_mem_writes", i), wr_cnt, vecs[i].wrs);
      chk($sformatf("v%0d_ready_in_miss", i), 32'(rdy_seen), 32'd0);
      if (vecs[i].miss) chk($sformatf("v%0d_fill_addr", i), last_rd_addr, vecs[i].rd_addr);
    end

    chk("wb0_addr", first_wr_addr, 32'h0);
    chk("wb0_word1", first_wr_data[63:32], 32'hDEADBEEF);
    chk("wb0_word0", first_wr_data[31:0], 32'h0);
    chk("wb1_addr", last_wr_addr, 32'h20);
    chk("wb1_word2", last_wr_data[95:64], 32'h12345678);

    // Reset while the refill for 0x300 is outstanding.
    @(negedge clk);
    is_input_valid = 1'b1;
    mem_read       = 1'b1;
    addr           = 32'h0000_0300;
    found          = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (lat != 2'd0 && pend_rd) begin
        found = 1'b1;
        break;
      end
    end
    chk("fillwait_reached", 32'(found), 32'd1);
    chk("fillwait_not_ready", 32'(is_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("midrst_is_ready", 32'(is_ready), 32'd1);
    chk("midrst_is_hit", 32'(is_hit), 32'd0);
    chk("midrst_out_valid", 32'(is_output_valid), 32'd0);
    chk("midrst_mem_valid", 32'(mem_is_input_valid), 32'd0);
    chk("midrst_mem_rd", 32'(mem_rd), 32'd0);
    chk("midrst_hit_count", hit_count, 32'd0);
    chk("midrst_miss_count", miss_count, 32'd0);
    @(negedge clk);
    is_input_valid = 1'b0;
    mem_read       = 1'b0;
    reset          = 1'b0;

    access(1'b1, 1'b0, 32'h0000_0004, 32'h0, missed, data, ovalid, rdy_seen, ok);
    chk("postrst_done", 32'(ok), 32'd1);
    chk("postrst_miss", 32'(missed), 32'd1);
    chk("postrst_dout", data, 32'h0);
    chk("postrst_hit_count", hit_count, 32'd0);
    chk("postrst_miss_count", miss_count, 32'd1);

    bad_rdy = 0;
    bad_req = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!is_ready) bad_rdy++;
      if (mem_is_input_valid) bad_req++;
    end
    chk("idle_ready", 32'(bad_rdy), 32'd0);
    chk("idle_mem_req", 32'(bad_req), 32'd0);
    chk("idle_hit_count", hit_count, 32'd0);
    chk("idle_miss_count", miss_count, 32'd1);
    chk("idle_mem_reads", rd_cnt, 32'd1);
    chk("idle_mem_writes", wr_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
